rf_hazard_scoreboard: RTL and testbench

- Scoreboard and stall sequencer for the 16-entry register file in the 4-stage pipeline (ID -> EX -> MEM -> WB, RF written at WB).
- Tracks in-flight writes per register.
- On a read-after-write hazard it freezes fetch (HZPCld), freezes IF/ID and inserts a control bubble.
- Writes targeting R15 (PC) hold fetch until the new PC is written back.

---
 rtl/hz_pkg.sv | 14 +
 rtl/hz_pend_counter.sv | 34 +++
 rtl/rf_hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_rf_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hz_pkg.sv
// Shared types and defaults for the register-file hazard scoreboard.
// Build option HZ_STALL_COUNTER_EN (used in rf_hazard_scoreboard) enables the stall performance counter.
package hz_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    PCWAIT = 1'b1
  } hz_state_t;

  localparam int NREG       = 16;
  localparam int PC_REG_DEF = 15;
  localparam int CNT_W_DEF  = 2;

endpackage

// File: rtl/hz_pend_counter.sv
// One saturating up/down pending-write counter for a single register.
// err flags an increment at max or a decrement at zero in the current cycle.
module hz_pend_counter #(
  parameter int CNT_W = hz_pkg::CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic dec,
  output logic err,
  output logic nonzero
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt;

  always_comb begin
    err     = (inc & ~dec & (cnt == CNT_MAX)) | (dec & ~inc & (cnt == '0));
    nonzero = |cnt;
  end

  // Simultaneous inc and dec cancel; otherwise move toward the bound but never past it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (inc & ~dec & (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end else if (dec & ~inc & (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/rf_hazard_scoreboard.sv
// Read-after-write scoreboard and stall sequencer for the 16-entry RF of the 4-stage pipeline.
// Define HZ_STALL_COUNTER_EN to build the STALL_CYCLES counter; otherwise it reads as zero.
module rf_hazard_scoreboard
  import hz_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PC_REG = PC_REG_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ID_VALID,
  input  logic [3:0]  ID_SA,
  input  logic [3:0]  ID_SB,
  input  logic [3:0]  ID_SD,
  input  logic [2:0]  ID_USE,
  input  logic        ID_RFLd,
  input  logic [3:0]  ID_C,
  input  logic        WB_RFLd,
  input  logic [3:0]  WB_C,
  output logic        HZPCld,
  output logic        IFID_Ld,
  output logic        CU_NOP,
  output logic [15:0] BUSY,
  output logic        PEND_ERR,
  output logic [15:0] STALL_CYCLES
);

  localparam logic [3:0] PC_IDX = 4'(PC_REG);

  hz_state_t        state, next_state;
  logic             hazard;
  logic             issue;
  logic [2:0]       src_busy;
  logic [NREG-1:0]  inc_vec;
  logic [NREG-1:0]  dec_vec;
  logic [NREG-1:0]  err_vec;

  // A WB to a source in this same cycle does not clear the hazard; the RF write lands at the edge.
  always_comb begin
    src_busy = {BUSY[ID_SD], BUSY[ID_SB], BUSY[ID_SA]};
    hazard   = ID_VALID & |(ID_USE & src_busy);
    issue    = ID_VALID & ~hazard & (state == RUN);
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = issue & ID_RFLd & (ID_C == 4'(r));
      dec_vec[r] = WB_RFLd & (WB_C == 4'(r));
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_pend
    hz_pend_counter #(.CNT_W(CNT_W)) u_cnt (
      .CLK     (CLK),
      .RST     (RST),
      .inc     (inc_vec[g]),
      .dec     (dec_vec[g]),
      .err     (err_vec[g]),
      .nonzero (BUSY[g])
    );
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // PCWAIT holds fetch and bubbles ID until the new PC has been written back.
  always_comb begin
    next_state = state;
    HZPCld     = 1'b0;
    IFID_Ld    = 1'b0;
    CU_NOP     = 1'b1;
    case (state)
      RUN: begin
        HZPCld  = ~hazard;
        IFID_Ld = ~hazard;
        CU_NOP  = hazard | ~ID_VALID;
        if (issue & ID_RFLd & (ID_C == PC_IDX)) begin
          next_state = PCWAIT;
        end
      end
      PCWAIT: begin
        if (WB_RFLd & (WB_C == PC_IDX)) begin
          next_state = RUN;
        end
      end
      default: next_state = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PEND_ERR <= 1'b0;
    end else if (|err_vec) begin
      PEND_ERR <= 1'b1;
    end
  end

`ifdef HZ_STALL_COUNTER_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (~HZPCld & (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign STALL_CYCLES = stall_cnt;
`else
  assign STALL_CYCLES = 16'h0000;
`endif

endmodule

// File: tb/tb_rf_hazard_scoreboard.sv
// Directed bench for rf_hazard_scoreboard; expected outputs are queued per step and popped when sampled.
// Honors HZ_STALL_COUNTER_EN for the expected STALL_CYCLES values.
module tb_rf_hazard_scoreboard;

  logic        CLK;
  logic        RST;
  logic        ID_VALID;
  logic [3:0]  ID_SA, ID_SB, ID_SD, ID_C, WB_C;
  logic [2:0]  ID_USE;
  logic        ID_RFLd, WB_RFLd;
  logic        HZPCld, IFID_Ld, CU_NOP, PEND_ERR;
  logic [15:0] BUSY, STALL_CYCLES;

`ifdef HZ_STALL_COUNTER_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    string       tag;
    logic        hz;
    logic        ifid;
    logic        nop;
    logic [15:0] busy;
    logic        err;
    logic [15:0] stall;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   stall_model  = 0;

  rf_hazard_scoreboard dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_VALID     (ID_VALID),
    .ID_SA        (ID_SA),
    .ID_SB        (ID_SB),
    .ID_SD        (ID_SD),
    .ID_USE       (ID_USE),
    .ID_RFLd      (ID_RFLd),
    .ID_C         (ID_C),
    .WB_RFLd      (WB_RFLd),
    .WB_C         (WB_C),
    .HZPCld       (HZPCld),
    .IFID_Ld      (IFID_Ld),
    .CU_NOP       (CU_NOP),
    .BUSY         (BUSY),
    .PEND_ERR     (PEND_ERR),
    .STALL_CYCLES (STALL_CYCLES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic compare(input string tag, input string field,
                         input logic [15:0] obs, input logic [15:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, expv);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      compare(e.tag, "HZPCld",       {15'd0, HZPCld},   {15'd0, e.hz});
      compare(e.tag, "IFID_Ld",      {15'd0, IFID_Ld},  {15'd0, e.ifid});
      compare(e.tag, "CU_NOP",       {15'd0, CU_NOP},   {15'd0, e.nop});
      compare(e.tag, "BUSY",         BUSY,              e.busy);
      compare(e.tag, "PEND_ERR",     {15'd0, PEND_ERR}, {15'd0, e.err});
      compare(e.tag, "STALL_CYCLES", STALL_CYCLES,      e.stall);
    end
  endtask

  // Drive one decode/writeback cycle and queue the outputs expected before the next edge.
  task automatic applyStimulus(input string tag, input logic valid,
                               input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] sd,
                               input logic [2:0] use_f, input logic rfld, input logic [3:0] c,
                               input logic wbld, input logic [3:0] wbc,
                               input logic hz, input logic nop, input logic [15:0] busy,
                               input logic err);
    exp_t e;
    @(negedge CLK);
    ID_VALID = valid;
    ID_SA    = sa;
    ID_SB    = sb;
    ID_SD    = sd;
    ID_USE   = use_f;
    ID_RFLd  = rfld;
    ID_C     = c;
    WB_RFLd  = wbld;
    WB_C     = wbc;
    e.tag   = tag;
    e.hz    = hz;
    e.ifid  = hz;
    e.nop   = nop;
    e.busy  = busy;
    e.err   = err;
    e.stall = STALL_EN ? 16'(stall_model) : 16'h0000;
    exp_q.push_back(e);
    #1;
    checkOutput();
    if (!hz) stall_model++;
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear without a clock.
  task automatic resetCheck(input string tag);
    exp_t e;
    ID_VALID = 1'b1;
    ID_USE   = 3'b000;
    ID_RFLd  = 1'b0;
    WB_RFLd  = 1'b0;
    RST      = 1'b1;
    stall_model = 0;
    e.tag   = tag;
    e.hz    = 1'b1;
    e.ifid  = 1'b1;
    e.nop   = 1'b0;
    e.busy  = 16'h0000;
    e.err   = 1'b0;
    e.stall = 16'h0000;
    exp_q.push_back(e);
    #1;
    checkOutput();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    ID_VALID = 1'b0; ID_SA = '0; ID_SB = '0; ID_SD = '0; ID_USE = '0;
    ID_RFLd = 1'b0; ID_C = '0; WB_RFLd = 1'b0; WB_C = '0; RST = 1'b0;
    resetCheck("reset_init");

    // RAW on R3: three stall cycles, WB in the third does not release early
    applyStimulus("prod_r3",     1, 0, 0, 0, 3'b000, 1, 3,  0, 0, 1, 0, 16'h0000, 0);
    applyStimulus("dep_r3_s1",   1, 3, 0, 0, 3'b001, 1, 4,  0, 0, 0, 1, 16'h0008, 0);
    applyStimulus("dep_r3_s2",   1, 3, 0, 0, 3'b001, 1, 4,  0, 0, 0, 1, 16'h0008, 0);
    applyStimulus("dep_r3_wb",   1, 3, 0, 0, 3'b001, 1, 4,  1, 3, 0, 1, 16'h0008, 0);
    applyStimulus("dep_r3_iss",  1, 3, 0, 0, 3'b001, 1, 4,  0, 0, 1, 0, 16'h0000, 0);
    applyStimulus("retire_r4",   0, 0, 0, 0, 3'b000, 0, 0,  1, 4, 1, 1, 16'h0010, 0);

    // Two writes to R5 in flight; dependent via SB waits for both
    applyStimulus("w5_a",        1, 0, 0, 0, 3'b000, 1, 5,  0, 0, 1, 0, 16'h0000, 0);
    applyStimulus("w5_b",        1, 0, 0, 0, 3'b000, 1, 5,  0, 0, 1, 0, 16'h0020, 0);
    applyStimulus("dep5_s1",     1, 0, 5, 0, 3'b010, 0, 0,  0, 0, 0, 1, 16'h0020, 0);
    applyStimulus("dep5_wb1",    1, 0, 5, 0, 3'b010, 0, 0,  1, 5, 0, 1, 16'h0020, 0);
    applyStimulus("dep5_s3",     1, 0, 5, 0, 3'b010, 0, 0,  0, 0, 0, 1, 16'h0020, 0);
    applyStimulus("dep5_wb2",    1, 0, 5, 0, 3'b010, 0, 0,  1, 5, 0, 1, 16'h0020, 0);
    applyStimulus("dep5_iss",    1, 0, 5, 0, 3'b010, 0, 0,  0, 0, 1, 0, 16'h0000, 0);

    // Same-edge inc and dec on R7 cancel; dependent via SD then issues an R15 write
    applyStimulus("w7",          1, 0, 0, 0, 3'b000, 1, 7,  0, 0, 1, 0, 16'h0000, 0);
    applyStimulus("w7_and_wb7",  1, 0, 0, 0, 3'b000, 1, 7,  1, 7, 1, 0, 16'h0080, 0);
    applyStimulus("dep7_sd",     1, 0, 0, 7, 3'b100, 1, 15, 0, 0, 0, 1, 16'h0080, 0);
    applyStimulus("dep7_wb",     1, 0, 0, 7, 3'b100, 1, 15, 1, 7, 0, 1, 16'h0080, 0);
    applyStimulus("w15_issue",   1, 0, 0, 7, 3'b100, 1, 15, 0, 0, 1, 0, 16'h0000, 0);

    // PCWAIT holds even independent instructions until R15 writes back
    applyStimulus("pcwait_1",    1, 1, 0, 0, 3'b001, 1, 2,  0, 0, 0, 1, 16'h8000, 0);
    applyStimulus("pcwait_2",    1, 1, 0, 0, 3'b001, 1, 2,  0, 0, 0, 1, 16'h8000, 0);
    applyStimulus("pcwait_wb",   1, 1, 0, 0, 3'b001, 1, 2,  1, 15, 0, 1, 16'h8000, 0);
    applyStimulus("pc_run",      1, 1, 0, 0, 3'b001, 0, 2,  0, 0, 1, 0, 16'h0000, 0);

    // Underflow on R9 sets the sticky error
    applyStimulus("uflow_r9",    0, 0, 0, 0, 3'b000, 0, 0,  1, 9, 1, 1, 16'h0000, 0);
    applyStimulus("uflow_stick", 0, 0, 0, 0, 3'b000, 0, 0,  0, 0, 1, 1, 16'h0000, 1);
    applyStimulus("uflow_stick2",0, 0, 0, 0, 3'b000, 0, 0,  0, 0, 1, 1, 16'h0000, 1);
    @(negedge CLK);
    #2;
    resetCheck("reset_clr_err");

    // Four writes to R2 saturate at 3; three WBs then drain it
    applyStimulus("sat_1",       1, 0, 0, 0, 3'b000, 1, 2,  0, 0, 1, 0, 16'h0000, 0);
    applyStimulus("sat_2",       1, 0, 0, 0, 3'b000, 1, 2,  0, 0, 1, 0, 16'h0004, 0);
    applyStimulus("sat_3",       1, 0, 0, 0, 3'b000, 1, 2,  0, 0, 1, 0, 16'h0004, 0);
    applyStimulus("sat_4",       1, 0, 0, 0, 3'b000, 1, 2,  0, 0, 1, 0, 16'h0004, 0);
    applyStimulus("sat_err",     0, 0, 0, 0, 3'b000, 0, 0,  0, 0, 1, 1, 16'h0004, 1);
    applyStimulus("sat_wb1",     0, 0, 0, 0, 3'b000, 0, 0,  1, 2, 1, 1, 16'h0004, 1);
    applyStimulus("sat_wb2",     0, 0, 0, 0, 3'b000, 0, 0,  1, 2, 1, 1, 16'h0004, 1);
    applyStimulus("sat_wb3",     0, 0, 0, 0, 3'b000, 0, 0,  1, 2, 1, 1, 16'h0004, 1);
    applyStimulus("sat_drained", 0, 0, 0, 0, 3'b000, 0, 0,  0, 0, 1, 1, 16'h0000, 1);

    // Reset in the middle of PCWAIT returns straight to RUN
    applyStimulus("pc_again",    1, 0, 0, 0, 3'b000, 1, 15, 0, 0, 1, 0, 16'h0000, 1);
    applyStimulus("pc_hold",     1, 0, 0, 0, 3'b000, 0, 0,  0, 0, 0, 1, 16'h8000, 1);
    #2;
    resetCheck("reset_pcwait");
    applyStimulus("post_reset",  1, 0, 0, 0, 3'b000, 0, 0,  0, 0, 1, 0, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
